multi_mode_timer: RTL



---
 rtl/multi_mode_timer.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_mode_timer.sv
// -----------------------------------------------------------------------------
// multi_mode_timer
//
// HH:MM:SS timer with up/down counting, pause, per-field BCD loading with range
// checking, an 8-digit multiplexed seven-segment display with field blinking,
// and a 3-colour status LED. Everything runs on the single board clock.
//
// Parameters
//   CLK_FREQ    clock cycles per one-second tick (>= 4)
//   SCAN_CYCLES clock cycles each display digit stays lit (>= 1)
//   HOURS       hour modulus (2..24); hours run 0..HOURS-1
//
// Ports
//   clk_i       board clock, rising edge
//   rst_ni      asynchronous active-low reset, clears the time to 00:00:00
//   s_i         mode: 00 run, 01 set hours, 10 set minutes, 11 set seconds
//   dir_i       0 count up, 1 count down
//   pause_i     holds the time while in run mode
//   load_i      level load request, sampled every edge in a set mode
//   data_h_i    BCD tens digit of the load value
//   data_l_i    BCD units digit of the load value
//   segs_o      active-low segments, bit 0 = a ... bit 6 = g
//   an_o        active-low digit enables, an[7:6] hours, an[4:3] minutes,
//               an[1:0] seconds, an[5] and an[2] show a dash
//   ledout_o    [0] running, [1] setting, [2] expired or load error
// -----------------------------------------------------------------------------
module multi_mode_timer #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SCAN_CYCLES = 100_000,
    parameter int HOURS       = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] s_i,
    input  logic       dir_i,
    input  logic       pause_i,
    input  logic       load_i,
    input  logic [3:0] data_h_i,
    input  logic [3:0] data_l_i,
    output logic [6:0] segs_o,
    output logic [7:0] an_o,
    output logic [2:0] ledout_o
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam int SW = $clog2(SCAN_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_SET_SEC = 2'b11
    } mode_e;

    // Six BCD digits, most significant first.
    typedef struct packed {
        logic [3:0] ht;
        logic [3:0] hu;
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } time_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic int hour_val(input time_t t);
        return int'(t.ht) * 10 + int'(t.hu);
    endfunction

    function automatic time_t inc_time(input time_t t);
        time_t r;
        r = t;
        if (t.su != 4'd9) begin
            r.su = t.su + 4'd1;
        end else begin
            r.su = 4'd0;
            if (t.st != 4'd5) begin
                r.st = t.st + 4'd1;
            end else begin
                r.st = 4'd0;
                if (t.mu != 4'd9) begin
                    r.mu = t.mu + 4'd1;
                end else begin
                    r.mu = 4'd0;
                    if (t.mt != 4'd5) begin
                        r.mt = t.mt + 4'd1;
                    end else begin
                        r.mt = 4'd0;
                        if (hour_val(t) == HOURS - 1) begin
                            r.ht = 4'd0;
                            r.hu = 4'd0;
                        end else if (t.hu == 4'd9) begin
                            r.hu = 4'd0;
                            r.ht = t.ht + 4'd1;
                        end else begin
                            r.hu = t.hu + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Borrow chain; 00:00:00 is returned unchanged so the countdown holds.
    function automatic time_t dec_time(input time_t t);
        time_t r;
        r = t;
        if (t != '0) begin
            if (t.su != 4'd0) begin
                r.su = t.su - 4'd1;
            end else begin
                r.su = 4'd9;
                if (t.st != 4'd0) begin
                    r.st = t.st - 4'd1;
                end else begin
                    r.st = 4'd5;
                    if (t.mu != 4'd0) begin
                        r.mu = t.mu - 4'd1;
                    end else begin
                        r.mu = 4'd9;
                        if (t.mt != 4'd0) begin
                            r.mt = t.mt - 4'd1;
                        end else begin
                            r.mt = 4'd5;
                            if (t.hu != 4'd0) begin
                                r.hu = t.hu - 4'd1;
                            end else begin
                                r.hu = 4'd9;
                                r.ht = t.ht - 4'd1;
                            end
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    idx_q, idx_d;
    time_t         time_q, time_d;
    logic          expired_q, expired_d;
    logic          error_q, error_d;
    logic [6:0]    segs_q, segs_d;
    logic [7:0]    an_q, an_d;
    logic [2:0]    ledout_q, ledout_d;

    mode_e         mode;
    logic          tick;
    logic          scan_wrap;
    logic          load_valid;
    int            load_val;
    int            load_limit;
    logic [3:0]    digit;
    logic          dash;
    logic          in_field;
    logic          blank;

    assign mode = mode_e'(s_i);
    assign tick = (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------
    // Time keeping, load and status flags
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        presc_d    = tick ? '0 : presc_q + 1'b1;
        time_d     = time_q;
        expired_d  = expired_q;
        error_d    = error_q;
        load_val   = int'(data_h_i) * 10 + int'(data_l_i);
        load_limit = (mode == MODE_SET_HR) ? HOURS : 60;
        load_valid = (data_h_i <= 4'd9) && (data_l_i <= 4'd9) && (load_val < load_limit);

        if (mode == MODE_RUN) begin
            error_d = 1'b0;
            if (tick && !pause_i) begin
                if (!dir_i) begin
                    time_d    = inc_time(time_q);
                    expired_d = 1'b0;
                end else begin
                    time_d = dec_time(time_q);
                    // Set both on arriving at zero and on each held tick at zero.
                    if (time_d == '0) begin
                        expired_d = 1'b1;
                    end
                end
            end
        end else if (load_i) begin
            if (load_valid) begin
                case (mode)
                    MODE_SET_HR:  begin time_d.ht = data_h_i; time_d.hu = data_l_i; end
                    MODE_SET_MIN: begin time_d.mt = data_h_i; time_d.mu = data_l_i; end
                    default:      begin time_d.st = data_h_i; time_d.su = data_l_i; end
                endcase
                error_d   = 1'b0;
                expired_d = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end

        ledout_d = {expired_d | error_d,
                    mode != MODE_RUN,
                    (mode == MODE_RUN) && !pause_i && !expired_d};
    end

    // ------------------------------------------------------------------
    // Display scan. The enables and blink follow the next scan index and
    // prescaler value, while the digit shown comes from the current time
    // register, so a time change appears on the display one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_MAX);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        // 3-bit decrement wraps 0 -> 7 on its own.
        idx_d      = scan_wrap ? idx_q - 3'd1 : idx_q;

        digit    = 4'd0;
        dash     = 1'b0;
        in_field = 1'b0;
        case (idx_d)
            3'd7: begin digit = time_q.ht; in_field = (mode == MODE_SET_HR);  end
            3'd6: begin digit = time_q.hu; in_field = (mode == MODE_SET_HR);  end
            3'd4: begin digit = time_q.mt; in_field = (mode == MODE_SET_MIN); end
            3'd3: begin digit = time_q.mu; in_field = (mode == MODE_SET_MIN); end
            3'd1: begin digit = time_q.st; in_field = (mode == MODE_SET_SEC); end
            3'd0: begin digit = time_q.su; in_field = (mode == MODE_SET_SEC); end
            default: dash = 1'b1;
        endcase

        blank  = in_field && (presc_d >= PRESC_HALF);
        segs_d = blank ? SEG_BLANK : (dash ? SEG_DASH : seg_decode(digit));
        an_d   = ~(8'b0000_0001 << idx_d);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            presc_q    <= '0;
            scan_cnt_q <= '0;
            idx_q      <= 3'd7;
            time_q     <= '0;
            expired_q  <= 1'b0;
            error_q    <= 1'b0;
            segs_q     <= 7'b1000000;
            an_q       <= 8'b0111_1111;
            ledout_q   <= 3'b001;
        end else begin
            presc_q    <= presc_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            time_q     <= time_d;
            expired_q  <= expired_d;
            error_q    <= error_d;
            segs_q     <= segs_d;
            an_q       <= an_d;
            ledout_q   <= ledout_d;
        end
    end

    assign segs_o   = segs_q;
    assign an_o     = an_q;
    assign ledout_o = ledout_q;

endmodule
